// File: rtl/cmu_pkg.sv
// Shared constants, FSM state codes and byte-lane helpers for the data-cache controller.
package cmu_pkg;
  localparam int CMU_ADDR_W     = 32;
  localparam int CMU_WORD_W     = 32;
  localparam int CMU_LINE_WORDS = 4;
  localparam int CMU_SETS       = 64;
  localparam int CMU_WO_W       = $clog2(CMU_LINE_WORDS);
  localparam int CMU_OFF_W      = CMU_WO_W + 2;
  localparam int CMU_IDX_W      = $clog2(CMU_SETS);
  localparam int CMU_TAG_W      = CMU_ADDR_W - CMU_IDX_W - CMU_OFF_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WB     = 2'd1;
  localparam logic [1:0] REFILL = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Low address bits below the access size are ignored (forced alignment).
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] a,
                                              input logic [2:0] ubhw);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = word[{a[1], 4'b0000} +: 16];
    case (ubhw[1:0])
      SZ_B:    load_extend = ubhw[2] ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    load_extend = ubhw[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [1:0] a, input logic [1:0] size);
    store_merge = old_w;
    case (size)
      SZ_B:    store_merge[{a, 3'b000} +: 8]     = new_w[7:0];
      SZ_H:    store_merge[{a[1], 4'b0000} +: 16] = new_w[15:0];
      default: store_merge = new_w;
    endcase
  endfunction
endpackage

// File: rtl/cache_mgmt_unit_if.sv
// Word-serial memory handshake between the cache controller (master) and main memory (slave).
interface cache_mgmt_unit_if import cmu_pkg::*; #(
  parameter int ADDR_W = CMU_ADDR_W,
  parameter int WORD_W = CMU_WORD_W
);
  logic              mem_cs_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WORD_W-1:0] mem_data_o;
  logic [WORD_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport master (output mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
                  input  mem_data_i, mem_ack_i);
  modport slave  (input  mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
                  output mem_data_i, mem_ack_i);
endinterface

// File: rtl/cache_array.sv
// Two-way tag/valid/dirty/LRU/data storage with combinational read of one set.
module cache_array import cmu_pkg::*; #(
  parameter int WORD_W     = CMU_WORD_W,
  parameter int LINE_WORDS = CMU_LINE_WORDS,
  parameter int SETS       = CMU_SETS,
  parameter int WO_W       = $clog2(LINE_WORDS),
  parameter int IDX_W      = $clog2(SETS),
  parameter int TAG_W      = CMU_TAG_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [IDX_W-1:0]                       i_idx,
  output logic [1:0][TAG_W-1:0]                  o_tag,
  output logic [1:0]                             o_valid,
  output logic [1:0]                             o_dirty,
  output logic                                   o_lru,
  output logic [1:0][LINE_WORDS-1:0][WORD_W-1:0] o_data,
  input  logic                                   i_wr_en,
  input  logic                                   i_wr_way,
  input  logic [WO_W-1:0]                        i_wr_word,
  input  logic [WORD_W-1:0]                      i_wr_data,
  input  logic                                   i_set_dirty,
  input  logic                                   i_fill,
  input  logic [TAG_W-1:0]                       i_fill_tag,
  input  logic                                   i_lru_we,
  input  logic                                   i_lru_val
);
  logic [TAG_W-1:0]  r_tag  [2][SETS];
  logic [WORD_W-1:0] r_data [2][SETS][LINE_WORDS];
  logic [SETS-1:0]   r_valid [2];
  logic [SETS-1:0]   r_dirty [2];
  logic [SETS-1:0]   r_lru;

  for (genvar gw = 0; gw < 2; gw++) begin : g_way
    assign o_tag[gw]   = r_tag[gw][i_idx];
    assign o_valid[gw] = r_valid[gw][i_idx];
    assign o_dirty[gw] = r_dirty[gw][i_idx];
    for (genvar gk = 0; gk < LINE_WORDS; gk++) begin : g_word
      assign o_data[gw][gk] = r_data[gw][i_idx][gk];
    end
  end
  assign o_lru = r_lru[i_idx];

  // o_lru names the way to evict next in this set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru      <= '0;
    end else begin
      if (i_fill) begin
        r_valid[i_wr_way][i_idx] <= 1'b1;
        r_dirty[i_wr_way][i_idx] <= 1'b0;
      end else if (i_wr_en && i_set_dirty) begin
        r_dirty[i_wr_way][i_idx] <= 1'b1;
      end
      if (i_lru_we) begin
        r_lru[i_idx] <= i_lru_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_way][i_idx][i_wr_word] <= i_wr_data;
    end
    if (i_fill) begin
      r_tag[i_wr_way][i_idx] <= i_fill_tag;
    end
  end
endmodule

// File: rtl/cache_mgmt_unit.sv
// 2-way write-back, write-allocate data cache controller with victim writeback and refill FSM.
module cache_mgmt_unit import cmu_pkg::*; #(
  parameter int ADDR_W     = CMU_ADDR_W,
  parameter int WORD_W     = CMU_WORD_W,
  parameter int LINE_WORDS = CMU_LINE_WORDS,
  parameter int SETS       = CMU_SETS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_rw,
  input  logic              en_r,
  input  logic              en_w,
  input  logic [2:0]        u_b_h_w,
  input  logic [WORD_W-1:0] data_w,
  output logic [WORD_W-1:0] data_r,
  output logic              cmu_stall,
  cache_mgmt_unit_if.master mem
);
  localparam int WO_W  = $clog2(LINE_WORDS);
  localparam int OFF_W = WO_W + 2;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [WO_W-1:0] LAST_WORD = WO_W'(LINE_WORDS - 1);

  logic [1:0]      r_state, w_nxt_state;
  logic [WO_W-1:0] r_word_cnt, w_nxt_cnt;
  logic            r_victim, w_victim;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [WO_W-1:0]  w_word;
  logic [1:0][TAG_W-1:0]                  w_tags;
  logic [1:0]                             w_valid, w_dirty, w_hit_way;
  logic                                   w_lru, w_hit, w_hit_sel, w_req;
  logic [1:0][LINE_WORDS-1:0][WORD_W-1:0] w_data;
  logic [WORD_W-1:0]                      w_hit_word;

  logic              w_wr_en, w_wr_way, w_set_dirty, w_fill, w_lru_we;
  logic [WO_W-1:0]   w_wr_word;
  logic [WORD_W-1:0] w_wr_data;

  assign w_tag      = addr_rw[ADDR_W-1 -: TAG_W];
  assign w_idx      = addr_rw[OFF_W +: IDX_W];
  assign w_word     = addr_rw[2 +: WO_W];
  assign w_req      = en_r | en_w;
  assign w_hit_way  = {w_valid[1] && (w_tags[1] == w_tag), w_valid[0] && (w_tags[0] == w_tag)};
  assign w_hit      = |w_hit_way;
  assign w_hit_sel  = w_hit_way[1];
  assign w_hit_word = w_data[w_hit_sel][w_word];

  cache_array #(
    .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS),
    .WO_W(WO_W), .IDX_W(IDX_W), .TAG_W(TAG_W)
  ) u_array (
    .clk(clk), .rst(rst), .i_idx(w_idx),
    .o_tag(w_tags), .o_valid(w_valid), .o_dirty(w_dirty), .o_lru(w_lru), .o_data(w_data),
    .i_wr_en(w_wr_en), .i_wr_way(w_wr_way), .i_wr_word(w_wr_word), .i_wr_data(w_wr_data),
    .i_set_dirty(w_set_dirty), .i_fill(w_fill), .i_fill_tag(w_tag),
    .i_lru_we(w_lru_we), .i_lru_val(~w_hit_sel)
  );

  // Prefer an empty way before evicting the LRU one.
  always_comb begin
    if (!w_valid[0]) begin
      w_victim = 1'b0;
    end else if (!w_valid[1]) begin
      w_victim = 1'b1;
    end else begin
      w_victim = w_lru;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_word_cnt;
    w_wr_en     = 1'b0;
    w_wr_way    = r_victim;
    w_wr_word   = r_word_cnt;
    w_wr_data   = mem.mem_data_i;
    w_set_dirty = 1'b0;
    w_fill      = 1'b0;
    w_lru_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && w_hit) begin
          w_lru_we = 1'b1;
          if (en_w) begin
            w_wr_en     = 1'b1;
            w_wr_way    = w_hit_sel;
            w_wr_word   = w_word;
            w_wr_data   = store_merge(w_hit_word, data_w, addr_rw[1:0], u_b_h_w[1:0]);
            w_set_dirty = 1'b1;
          end else begin
            w_wr_en = 1'b0;
          end
        end else if (w_req) begin
          w_nxt_state = (w_valid[w_victim] && w_dirty[w_victim]) ? WB : REFILL;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_state = IDLE;
        end
      end
      WB: begin
        if (mem.mem_ack_i) begin
          w_nxt_cnt   = r_word_cnt + 1'b1;
          w_nxt_state = (r_word_cnt == LAST_WORD) ? REFILL : WB;
        end else begin
          w_nxt_state = WB;
        end
      end
      REFILL: begin
        if (mem.mem_ack_i) begin
          w_wr_en     = 1'b1;
          w_nxt_cnt   = r_word_cnt + 1'b1;
          w_fill      = (r_word_cnt == LAST_WORD);
          w_nxt_state = (r_word_cnt == LAST_WORD) ? IDLE : REFILL;
        end else begin
          w_nxt_state = REFILL;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // Victim is chosen once, on the miss cycle, and held through WB/REFILL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_word_cnt <= '0;
      r_victim   <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_word_cnt <= w_nxt_cnt;
      if (r_state == IDLE && w_req && !w_hit) begin
        r_victim <= w_victim;
      end
    end
  end

  always_comb begin
    cmu_stall = !rst && ((r_state != IDLE) || (w_req && !w_hit));
    if (!rst && r_state == IDLE && en_r && !en_w && w_hit) begin
      data_r = load_extend(w_hit_word, addr_rw[1:0], u_b_h_w);
    end else begin
      data_r = '0;
    end
    mem.mem_cs_o   = (r_state != IDLE);
    mem.mem_we_o   = (r_state == WB);
    mem.mem_data_o = '0;
    case (r_state)
      WB: begin
        mem.mem_addr_o = {w_tags[r_victim], w_idx, r_word_cnt, 2'b00};
        mem.mem_data_o = w_data[r_victim][r_word_cnt];
      end
      REFILL:  mem.mem_addr_o = {w_tag, w_idx, r_word_cnt, 2'b00};
      default: mem.mem_addr_o = '0;
    endcase
  end
endmodule

// File: tb/tb_cache_mgmt_unit.sv
// Randomized and directed bench for cache_mgmt_unit against a transaction-level cache/memory model.
module tb_cache_mgmt_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_rw, data_w, data_r;
  logic        en_r, en_w, cmu_stall;
  logic [2:0]  u_b_h_w;

  cache_mgmt_unit_if #(.ADDR_W(32), .WORD_W(32)) mem_if ();

  cache_mgmt_unit dut (
    .clk(clk), .rst(rst), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
    .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .cmu_stall(cmu_stall), .mem(mem_if)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } xfer_t;

  logic [31:0] bmem [logic [31:0]];
  bit          m_valid [2][64];
  bit          m_dirty [2][64];
  logic [21:0] m_tag   [2][64];
  logic [31:0] m_data  [2][64][4];
  bit          m_lru   [64];
  xfer_t       expq [$];
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] u);
    logic [31:0] v;
    if (u[1:0] == 2'd0) begin
      v = (w >> (8 * a)) & 32'hFF;
      if (!u[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (u[1:0] == 2'd1) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (!u[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * a; mask = 32'hFF << sh;
    end else if (sz == 2'd1) begin
      sh = 16 * a[1]; mask = 32'hFFFF << sh;
    end else begin
      sh = 0; mask = 32'hFFFF_FFFF;
    end
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_valid[0][s] = 0; m_valid[1][s] = 0;
      m_dirty[0][s] = 0; m_dirty[1][s] = 0;
      m_lru[s] = 0;
    end
  endtask

  // One access from drive to completion; starts and ends just after a falling edge.
  task automatic do_access(input logic [31:0] a, input bit st, input bit both, input logic [2:0] ubhw,
                           input logic [31:0] d, input int ack_mode, input int abort_rd,
                           output int stalls, output logic [31:0] rdata);
    int idx, wd, way, nrd;
    bit miss, done;
    logic [21:0] tg;
    logic [31:0] line [4];
    logic [31:0] exp_rd;
    bit exp_cs, exp_stall, ack;
    idx = int'(a[9:4]); wd = int'(a[3:2]); tg = a[31:10];
    stalls = 0; rdata = 32'h0; nrd = 0; done = 0;
    expq.delete();
    miss = 1;
    way = 0;
    for (int w = 0; w < 2; w++)
      if (m_valid[w][idx] && m_tag[w][idx] == tg) begin miss = 0; way = w; end
    if (miss) begin
      way = !m_valid[0][idx] ? 0 : (!m_valid[1][idx] ? 1 : int'(m_lru[idx]));
      if (m_valid[way][idx] && m_dirty[way][idx])
        for (int k = 0; k < 4; k++)
          expq.push_back('{1'b1, {m_tag[way][idx], a[9:4], 2'(k), 2'b00}, m_data[way][idx][k]});
      for (int k = 0; k < 4; k++) begin
        expq.push_back('{1'b0, {tg, a[9:4], 2'(k), 2'b00}, 32'h0});
        line[k] = mem_rd({tg, a[9:4], 2'(k), 2'b00});
      end
    end else begin
      for (int k = 0; k < 4; k++) line[k] = m_data[way][idx][k];
    end
    exp_rd = m_load(line[wd], a[1:0], ubhw);
    addr_rw = a; u_b_h_w = ubhw; data_w = d;
    en_w = st; en_r = !st || both;
    for (int c = 0; c < 200; c++) begin
      if (ack_mode == 0) ack = 1;
      else if (ack_mode == 1) ack = (c % 3 == 0);
      else ack = 1'($urandom_range(0, 1));
      mem_if.mem_ack_i = ack;
      mem_if.mem_data_i = (expq.size() > 0 && !expq[0].we) ? mem_rd(expq[0].addr) : $urandom;
      #1;
      exp_cs = (c > 0) && (expq.size() > 0);
      exp_stall = (c == 0 && miss) || exp_cs;
      chk("stall", {31'd0, cmu_stall}, {31'd0, exp_stall});
      chk("mem_cs", {31'd0, mem_if.mem_cs_o}, {31'd0, exp_cs});
      if (exp_cs) begin
        chk("mem_we", {31'd0, mem_if.mem_we_o}, {31'd0, expq[0].we});
        chk("mem_addr", mem_if.mem_addr_o, expq[0].addr);
        if (expq[0].we) chk("mem_wdata", mem_if.mem_data_o, expq[0].data);
        if (ack) begin
          if (expq[0].we) bmem[expq[0].addr] = expq[0].data;
          else nrd++;
          void'(expq.pop_front());
        end
      end
      stalls += int'(cmu_stall);
      if (!exp_stall) begin
        if (!st) chk("load_data", data_r, exp_rd);
        rdata = data_r;
        done = 1;
      end
      @(posedge clk);
      if (abort_rd > 0 && nrd == abort_rd) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_stall", {31'd0, cmu_stall}, 32'd0);
        chk("rst_cs", {31'd0, mem_if.mem_cs_o}, 32'd0);
        chk("rst_we", {31'd0, mem_if.mem_we_o}, 32'd0);
        chk("rst_addr", mem_if.mem_addr_o, 32'd0);
        chk("rst_wdata", mem_if.mem_data_o, 32'd0);
        chk("rst_data_r", data_r, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      if (done) break;
    end
    if (!done) begin
      chk("timeout", 32'd1, 32'd0);
      return;
    end
    if (miss) begin
      for (int k = 0; k < 4; k++) m_data[way][idx][k] = line[k];
      m_tag[way][idx] = tg; m_valid[way][idx] = 1; m_dirty[way][idx] = 0;
    end
    if (st) begin
      m_data[way][idx][wd] = m_merge(m_data[way][idx][wd], d, a[1:0], ubhw[1:0]);
      m_dirty[way][idx] = 1;
    end
    m_lru[idx] = (way == 0);
  endtask

  task automatic idle_check();
    en_r = 0; en_w = 0; mem_if.mem_ack_i = 1'b1;
    #1;
    chk("idle_data_r", data_r, 32'd0);
    chk("idle_stall", {31'd0, cmu_stall}, 32'd0);
    chk("idle_cs", {31'd0, mem_if.mem_cs_o}, 32'd0);
    @(negedge clk);
  endtask

  int          st_n;
  logic [31:0] rd;
  logic [21:0] pool [4];
  logic [5:0]  sets [3];

  initial begin
    rst = 1'b1; en_r = 0; en_w = 0; addr_rw = 32'h0; u_b_h_w = 3'b010; data_w = 32'h0;
    mem_if.mem_ack_i = 1'b0; mem_if.mem_data_i = 32'h0;
    model_reset();
    for (int k = 0; k < 4; k++) bmem[32'h1000 + 32'(4 * k)] = 32'hA0 + 32'(k);
    bmem[32'h3070] = 32'h80FF_7F01;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset_stall", {31'd0, cmu_stall}, 32'd0);
    chk("reset_cs", {31'd0, mem_if.mem_cs_o}, 32'd0);
    chk("reset_data_r", data_r, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_access(32'h1004, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    chk("cold_stall", 32'(st_n), 32'd5);
    chk("cold_data", rd, 32'h0000_00A1);
    do_access(32'h1004, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    chk("rehit_stall", 32'(st_n), 32'd0);
    do_access(32'h1005, 1, 0, 3'b000, 32'h80, 0, 0, st_n, rd);
    chk("store_hit_stall", 32'(st_n), 32'd0);
    do_access(32'h9004, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    chk("second_way_stall", 32'(st_n), 32'd5);
    do_access(32'h11004, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    chk("dirty_evict_stall", 32'(st_n), 32'd9);
    chk("wb_word1", mem_rd(32'h1004), 32'h0000_80A1);

    do_access(32'h2050, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    do_access(32'h4050, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    do_access(32'h2050, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    chk("lru_a_hit", 32'(st_n), 32'd0);
    do_access(32'h6050, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    do_access(32'h2050, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    chk("lru_a_kept", 32'(st_n), 32'd0);
    do_access(32'h4050, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    chk("lru_b_evicted", 32'(st_n), 32'd5);

    do_access(32'h3073, 0, 0, 3'b000, 32'h0, 0, 0, st_n, rd);
    chk("lb", rd, 32'hFFFF_FF80);
    do_access(32'h3073, 0, 0, 3'b100, 32'h0, 0, 0, st_n, rd);
    chk("lbu", rd, 32'h0000_0080);
    do_access(32'h3072, 0, 0, 3'b001, 32'h0, 0, 0, st_n, rd);
    chk("lh", rd, 32'hFFFF_80FF);
    do_access(32'h3070, 0, 0, 3'b101, 32'h0, 0, 0, st_n, rd);
    chk("lhu", rd, 32'h0000_7F01);
    idle_check();

    do_access(32'h5080, 0, 0, 3'b010, 32'h0, 1, 0, st_n, rd);
    chk("slow_ack_stall", 32'(st_n), 32'd13);
    do_access(32'h5084, 1, 1, 3'b010, 32'h1234_5678, 0, 0, st_n, rd);
    do_access(32'h5084, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    chk("both_en_store", rd, 32'h1234_5678);

    do_access(32'h70C0, 0, 0, 3'b010, 32'h0, 0, 2, st_n, rd);
    do_access(32'h70C0, 0, 0, 3'b010, 32'h0, 0, 0, st_n, rd);
    chk("post_reset_stall", 32'(st_n), 32'd5);

    pool[0] = 22'h4; pool[1] = 22'h24; pool[2] = 22'h44; pool[3] = 22'h1F3;
    sets[0] = 6'd0; sets[1] = 6'd5; sets[2] = 6'd9;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      bit          rs;
      ra = {pool[$urandom_range(0, 3)], sets[$urandom_range(0, 2)], 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3))};
      rs = 1'($urandom_range(0, 1));
      do_access(ra, rs, 1'($urandom_range(0, 1)),
                {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))}, $urandom,
                $urandom_range(0, 2), 0, st_n, rd);
      if ($urandom_range(0, 7) == 0) idle_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
